serv_dbus_responder: RTL and testbench

//  Wishbone-classic data-bus responder (target side) for the SERV dbus initiator.

---
 rtl/serv_dbus_responder_pkg.sv | 24 ++
 rtl/serv_dbus_ram.sv | 26 ++
 rtl/serv_dbus_responder.sv | 130 +++++++++++++
 tb/tb_serv_dbus_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serv_dbus_responder_pkg.sv
// Shared types for the SERV dbus responder: FSM states, captured request, window decode.
package serv_dbus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } req_t;

  // offset is already relative to the window base; compared in 33 bits so 4*depth cannot wrap
  function automatic logic in_window(input logic [31:0] offset, input int unsigned depth);
    logic [32:0] limit;
    limit = 33'(depth) << 2;
    return ({1'b0, offset} < limit);
  endfunction

endpackage

// File: rtl/serv_dbus_ram.sv
// DEPTH x 32 data memory with per-byte write enables and a registered read port; no reset.
module serv_dbus_ram #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] adr,
  input  logic [31:0]              wdat,
  output logic [31:0]              rdat
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 4; n++) begin
      if (we[n]) begin
        mem[adr][8*n +: 8] <= wdat[8*n +: 8];
      end
    end
    if (re) begin
      rdat <= mem[adr];
    end
  end

endmodule

// File: rtl/serv_dbus_responder.sv
// Wishbone-classic target for the SERV dbus: local RAM window, programmable wait states,
// and a sticky fault for accesses outside the window (which are still acked).
module serv_dbus_responder
  import serv_dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_fault,
  output logic [31:0] o_fault_adr
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0]  LAST_CNT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  req_t        req_q;
  req_t        req;
  logic        ack;
  logic        rd_hit_q;
  logic        fault;
  logic [31:0] fault_adr;

  logic [31:0] offset;
  logic        hit;
  logic        enter_ack;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdat;
  logic        unused_offset;

  // With no wait states the RAM is accessed on the capture edge itself,
  // so the request is taken straight from the bus while idle.
  always_comb begin
    req = req_q;
    if (state == ST_IDLE) begin
      req.adr = i_wb_adr;
      req.dat = i_wb_dat;
      req.sel = i_wb_sel;
      req.we  = i_wb_we;
    end
  end

  assign offset        = req.adr - BASE_ADR;
  assign hit           = in_window(offset, DEPTH);
  assign unused_offset = ^offset;

  assign enter_ack = (state == ST_IDLE && i_wb_cyc && NO_WAIT) ||
                     (state == ST_WAIT && cnt == LAST_CNT);

  // Gated by reset so an access in flight while reset is held never reaches memory.
  assign ram_we = (enter_ack && req.we && hit && i_rst_n) ? req.sel : '0;
  assign ram_re = enter_ack && !req.we && hit;

  serv_dbus_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (i_clk),
    .we   (ram_we),
    .re   (ram_re),
    .adr  (offset[AW+1:2]),
    .wdat (req.dat),
    .rdat (ram_rdat)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      ack       <= 1'b0;
      rd_hit_q  <= 1'b0;
      fault     <= 1'b0;
      fault_adr <= '0;
    end else begin
      ack <= enter_ack;
      unique case (state)
        ST_IDLE: begin
          if (i_wb_cyc) begin
            req_q <= req;
            cnt   <= '0;
            state <= NO_WAIT ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= ST_ACK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (enter_ack) begin
        rd_hit_q <= hit && !req.we;
        if (!hit) begin
          fault <= 1'b1;
          if (!fault) begin
            fault_adr <= req.adr;
          end
        end
      end
    end
  end

  assign o_wb_ack    = ack;
  assign o_wb_rdt    = (ack && rd_hit_q) ? ram_rdat : '0;
  assign o_fault     = fault;
  assign o_fault_adr = fault_adr;

endmodule

// File: tb/tb_serv_dbus_responder.sv
// Directed + randomized bench for serv_dbus_responder against a word-level memory/fault model.
module tb_serv_dbus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc       [2];
  logic [31:0] rdt       [2];
  logic        ack       [2];
  logic        fault     [2];
  logic [31:0] fault_adr [2];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] model_mem [int unsigned];
  logic        model_fault [2];
  logic [31:0] model_fadr  [2];

  always #5 clk = ~clk;

  serv_dbus_responder #(
    .DEPTH(256), .BASE_ADR(32'h0000_0000), .WAIT_CYCLES(0)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc[0]), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]),
    .o_fault(fault[0]), .o_fault_adr(fault_adr[0])
  );

  serv_dbus_responder #(
    .DEPTH(64), .BASE_ADR(32'h0000_1000), .WAIT_CYCLES(3)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc[1]), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]),
    .o_fault(fault[1]), .o_fault_adr(fault_adr[1])
  );

  function automatic int unsigned depth_of(input int d);
    return (d == 0) ? 256 : 64;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int unsigned wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = nw[8*n +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      model_fault[d] = 1'b0;
      model_fadr[d]  = '0;
    end
  endtask

  // One complete transfer on DUT d, checked against the model; leaves cyc low.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd_obs);
    logic [31:0]  off;
    logic         hit;
    int unsigned  key;
    logic [31:0]  exp_rd;
    int unsigned  lat;
    bit           drop_early;

    @(negedge clk);
    chk("idle_ack", {31'b0, ack[d]}, 32'd0);
    chk("idle_rdt", rdt[d], 32'd0);
    adr = a; dat = wd; sel = s; we = w; cyc[d] = 1'b1;

    off    = a - base_of(d);
    hit    = off < (4 * depth_of(d));
    key    = d * 65536 + (off >> 2);
    exp_rd = '0;
    if (hit) begin
      if (w) model_mem[key] = merge(model_mem.exists(key) ? model_mem[key] : 32'h0, wd, s);
      else if (model_mem.exists(key)) exp_rd = model_mem[key];
    end else if (!model_fault[d]) begin
      model_fault[d] = 1'b1;
      model_fadr[d]  = a;
    end

    drop_early = 1'($urandom_range(0, 1));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack[d]) begin
        lat = k;
        break;
      end
      chk("wait_rdt", rdt[d], 32'd0);
      if (k == 1) begin
        adr = $urandom; dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
        if (drop_early) cyc[d] = 1'b0;
      end
    end

    if (lat == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL ack_timeout: observed no ack expected ack after %0d cycles", 1 + wait_of(d));
    end else begin
      chk("latency", lat, 1 + wait_of(d));
      chk("ack_rdt", rdt[d], exp_rd);
      chk("fault", {31'b0, fault[d]}, {31'b0, model_fault[d]});
      chk("fault_adr", fault_adr[d], model_fadr[d]);
    end
    rd_obs = rdt[d];
    cyc[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] pool [8];
    logic [31:0] a;

    rst_n = 1'b0; cyc[0] = 1'b0; cyc[1] = 1'b0;
    adr = '0; dat = '0; sel = '0; we = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", {31'b0, ack[d]}, 32'd0);
      chk("rst_rdt", rdt[d], 32'd0);
      chk("rst_fault", {31'b0, fault[d]}, 32'd0);
      chk("rst_fault_adr", fault_adr[d], 32'd0);
    end
    rst_n = 1'b1;

    // zero-wait write/read
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, r);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, r);
    chk("w0_read", r, 32'hDEAD_BEEF);

    // byte lanes
    xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, r);
    xfer(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, r);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, r);
    chk("lanes_read", r, 32'h11BB_33DD);

    // three wait states, read ignores sel, sel=0 write is a no-op
    xfer(1, 1'b1, 32'h1008, 32'hCAFE_F00D, 4'hF, r);
    xfer(1, 1'b0, 32'h1008, 32'h0, 4'h0, r);
    chk("w3_read", r, 32'hCAFE_F00D);
    xfer(1, 1'b1, 32'h1008, 32'hFFFF_FFFF, 4'h0, r);
    xfer(1, 1'b0, 32'h1008, 32'h0, 4'hF, r);
    chk("sel0_read", r, 32'hCAFE_F00D);

    // reset mid-WAIT aborts a pending write and clears the fault
    xfer(1, 1'b1, 32'h1014, 32'h55AA_55AA, 4'hF, r);
    xfer(1, 1'b0, 32'h2000, 32'h0, 4'hF, r);
    chk("miss_read_w3", r, 32'h0);
    @(negedge clk);
    adr = 32'h1014; dat = 32'hFFFF_0000; sel = 4'hF; we = 1'b1; cyc[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, ack[1]}, 32'd0);
    chk("midrst_rdt", rdt[1], 32'd0);
    chk("midrst_fault", {31'b0, fault[1]}, 32'd0);
    chk("midrst_fault_adr", fault_adr[1], 32'd0);
    cyc[1] = 1'b0;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h1014, 32'h0, 4'hF, r);
    chk("midrst_word", r, 32'h55AA_55AA);

    // out-of-window accesses
    xfer(0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, r);
    xfer(0, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, r);
    chk("miss_fault_adr", fault_adr[0], 32'h8000_0000);
    xfer(0, 1'b1, 32'h9000_0000, 32'h8765_4321, 4'hF, r);
    chk("miss2_fault_adr", fault_adr[0], 32'h8000_0000);
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, 4'hF, r);
    chk("miss_read", r, 32'h0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, r);
    chk("miss_ram_intact", r, 32'h0BAD_F00D);

    // back-to-back pairs across the index wrap 255 -> 0
    for (int i = 0; i < 8; i++) begin
      a = ((252 + i) % 256) * 4;
      xfer(0, 1'b1, a, $urandom, 4'hF, r);
      xfer(0, 1'b0, a, 32'h0, 4'hF, r);
    end

    // randomized traffic on a small pool of words near both window edges
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        int unsigned idx;
        idx = (i < 4) ? i : depth_of(d) - 8 + i;
        pool[i] = base_of(d) + idx * 4;
        xfer(d, 1'b1, pool[i], $urandom, 4'hF, r);
      end
      for (int i = 0; i < 50; i++) begin
        int unsigned op;
        op = $urandom_range(0, 9);
        if (op < 4)
          xfer(d, 1'b1, pool[$urandom_range(0, 7)], $urandom, 4'($urandom), r);
        else if (op < 9)
          xfer(d, 1'b0, pool[$urandom_range(0, 7)], 32'h0, 4'($urandom), r);
        else
          xfer(d, 1'($urandom), base_of(d) + 4 * depth_of(d) + ($urandom_range(0, 1023) << 2),
               $urandom, 4'hF, r);
      end
    end

    @(negedge clk);
    chk("final_ack0", {31'b0, ack[0]}, 32'd0);
    chk("final_ack1", {31'b0, ack[1]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
